cnn_win_addr_gen: RTL and testbench



---
 rtl/cnn_pkg.sv | 14 +
 rtl/cnn_win_addr_gen.sv | 95 +++++++++
 tb/tb_cnn_win_addr_gen.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared window-walker state and geometry helpers for the CNN datapath
package cnn_pkg;

    typedef enum logic {RUN, DONE} win_state_t;

    function automatic int last_pos(input int dim, input int k, input int stride);
        return ((dim - k) / stride) * stride;
    endfunction

    function automatic int start_addr(input int w, input int k);
        return (k - 1) * w + k - 1;
    endfunction

endpackage

// File: rtl/cnn_win_addr_gen.sv
// cnn_win_addr_gen: counts written pixels and walks a KxK window, flagging when its last pixel is resident
module cnn_win_addr_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W        = 28,
    parameter int IMG_H        = 28,
    parameter int K            = 3,
    parameter int STRIDE       = 1,
    parameter int PIX_PER_WORD = 8,
    parameter int AW           = $clog2(IMG_W * IMG_H + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_clr,
    input  logic          wr_en,
    input  logic          win_adv,
    output logic [AW-1:0] addr_wr,
    output logic [AW-1:0] addr_rd,
    output logic [AW-1:0] win_row,
    output logic [AW-1:0] win_col,
    output logic          win_rdy,
    output logic          frame_done,
    output logic          ovf
);

    localparam logic [AW-1:0] LAST_COL = AW'(last_pos(IMG_W, K, STRIDE));
    localparam logic [AW-1:0] LAST_ROW = AW'(last_pos(IMG_H, K, STRIDE));
    localparam logic [AW-1:0] START    = AW'(start_addr(IMG_W, K));
    localparam logic [AW-1:0] STEP     = AW'(STRIDE);
    localparam logic [AW-1:0] ROW_STEP = AW'(STRIDE * IMG_W - last_pos(IMG_W, K, STRIDE));
    localparam logic [AW-1:0] WORD     = AW'(PIX_PER_WORD);
    localparam logic [AW-1:0] FULL     = AW'(IMG_W * IMG_H);

    if (K < 1 || K > IMG_W || K > IMG_H) begin : g_bad_k
        $error("cnn_win_addr_gen: K must satisfy 1 <= K <= min(IMG_W, IMG_H)");
    end
    if (STRIDE != 1 && STRIDE != 2) begin : g_bad_stride
        $error("cnn_win_addr_gen: STRIDE must be 1 or 2");
    end
    if (PIX_PER_WORD < 1 || (IMG_W * IMG_H) % PIX_PER_WORD != 0) begin : g_bad_word
        $error("cnn_win_addr_gen: IMG_W*IMG_H must be a multiple of PIX_PER_WORD");
    end

    win_state_t state, state_nxt;
    logic       adv, last_win;

    assign adv      = win_adv && win_rdy;
    assign last_win = win_col >= LAST_COL && win_row >= LAST_ROW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_wr <= '0;
            ovf     <= 1'b0;
        end else if (frame_clr) begin
            addr_wr <= '0;
            ovf     <= 1'b0;
        end else if (wr_en) begin
            if (addr_wr == FULL) ovf <= 1'b1;
            else addr_wr <= addr_wr + WORD;
        end
    end

    // addr_rd tracks the bottom-right pixel incrementally, so no multiplier is needed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_row <= '0;
            win_col <= '0;
            addr_rd <= START;
        end else if (frame_clr) begin
            win_row <= '0;
            win_col <= '0;
            addr_rd <= START;
        end else if (adv && win_col < LAST_COL) begin
            win_col <= win_col + STEP;
            addr_rd <= addr_rd + STEP;
        end else if (adv && win_row < LAST_ROW) begin
            win_col <= '0;
            win_row <= win_row + STEP;
            addr_rd <= addr_rd + ROW_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else state <= state_nxt;
    end

    always_comb state_nxt = frame_clr ? RUN : (adv && last_win) ? DONE : state;

    always_comb begin
        win_rdy    = state == RUN && addr_rd < addr_wr;
        frame_done = state == DONE;
    end

endmodule

// File: tb/tb_cnn_win_addr_gen.sv
// tb_cnn_win_addr_gen: random and directed checks of the window generator at STRIDE 1 and 2
module tb_cnn_win_addr_gen;
    import cnn_pkg::*;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int K    = 3;
    localparam int P    = 8;
    localparam int AW   = 10;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          fc[2], we[2], wa[2];
    logic [AW-1:0] addr_wr[2], addr_rd[2], win_row[2], win_col[2];
    logic          win_rdy[2], frame_done[2], ovf[2];

    int m_wr[2], m_idx[2];
    bit m_done[2], m_ovf[2];
    int checks = 0, passed = 0, fails = 0;

    always #5 clk = ~clk;

    cnn_win_addr_gen #(.IMG_W(W), .IMG_H(H), .K(K), .STRIDE(1), .PIX_PER_WORD(P), .AW(AW)) dut0 (
        .clk(clk), .rst(rst), .frame_clr(fc[0]), .wr_en(we[0]), .win_adv(wa[0]),
        .addr_wr(addr_wr[0]), .addr_rd(addr_rd[0]), .win_row(win_row[0]), .win_col(win_col[0]),
        .win_rdy(win_rdy[0]), .frame_done(frame_done[0]), .ovf(ovf[0])
    );

    cnn_win_addr_gen #(.IMG_W(W), .IMG_H(H), .K(K), .STRIDE(2), .PIX_PER_WORD(P), .AW(AW)) dut1 (
        .clk(clk), .rst(rst), .frame_clr(fc[1]), .wr_en(we[1]), .win_adv(wa[1]),
        .addr_wr(addr_wr[1]), .addr_rd(addr_rd[1]), .win_row(win_row[1]), .win_col(win_col[1]),
        .win_rdy(win_rdy[1]), .frame_done(frame_done[1]), .ovf(ovf[1])
    );

    // Reference model: windows numbered in raster order, geometry derived from the index
    function automatic int strd(input int i);
        return i + 1;
    endfunction

    function automatic int ncols(input int i);
        return (W - K) / strd(i) + 1;
    endfunction

    function automatic int nwin(input int i);
        return ncols(i) * ((H - K) / strd(i) + 1);
    endfunction

    function automatic int exp_row(input int i);
        return (m_idx[i] / ncols(i)) * strd(i);
    endfunction

    function automatic int exp_col(input int i);
        return (m_idx[i] % ncols(i)) * strd(i);
    endfunction

    function automatic int exp_rd(input int i);
        return (exp_row(i) + K - 1) * W + exp_col(i) + K - 1;
    endfunction

    function automatic bit exp_rdy(input int i);
        return !m_done[i] && exp_rd(i) < m_wr[i];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_wr[i] = 0;
            m_idx[i] = 0;
            m_done[i] = 0;
            m_ovf[i] = 0;
        end
    endtask

    task automatic m_update(input int i);
        bit rdy;
        rdy = exp_rdy(i);
        if (fc[i]) begin
            m_wr[i] = 0;
            m_idx[i] = 0;
            m_done[i] = 0;
            m_ovf[i] = 0;
        end else begin
            if (we[i]) begin
                if (m_wr[i] == NPIX) m_ovf[i] = 1;
                else m_wr[i] += P;
            end
            if (wa[i] && rdy) begin
                if (m_idx[i] == nwin(i) - 1) m_done[i] = 1;
                else m_idx[i]++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("addr_wr[%0d]", i), 32'(addr_wr[i]), 32'(m_wr[i]));
            chk($sformatf("addr_rd[%0d]", i), 32'(addr_rd[i]), 32'(exp_rd(i)));
            chk($sformatf("win_row[%0d]", i), 32'(win_row[i]), 32'(exp_row(i)));
            chk($sformatf("win_col[%0d]", i), 32'(win_col[i]), 32'(exp_col(i)));
            chk($sformatf("win_rdy[%0d]", i), 32'(win_rdy[i]), 32'(exp_rdy(i)));
            chk($sformatf("frame_done[%0d]", i), 32'(frame_done[i]), 32'(m_done[i]));
            chk($sformatf("ovf[%0d]", i), 32'(ovf[i]), 32'(m_ovf[i]));
        end
    endtask

    task automatic step(input logic f0, input logic w0, input logic a0,
                        input logic f1, input logic w1, input logic a1);
        fc[0] = f0; we[0] = w0; wa[0] = a0;
        fc[1] = f1; we[1] = w1; wa[1] = a1;
        @(posedge clk);
        m_update(0);
        m_update(1);
        #1;
        fc[0] = 0; we[0] = 0; wa[0] = 0;
        fc[1] = 0; we[1] = 0; wa[1] = 0;
        check_all();
    endtask

    task automatic rand_step(input int pw, input int pa);
        step(0, $urandom_range(99) < pw, $urandom_range(99) < pa,
             0, $urandom_range(99) < pw, $urandom_range(99) < pa);
    endtask

    task automatic run_done(input int pw, input int pa, input int max);
        for (int n = 0; n < max && !(m_done[0] && m_done[1]); n++) rand_step(pw, pa);
        chk("reach_done0", 32'(frame_done[0]), 1);
        chk("reach_done1", 32'(frame_done[1]), 1);
    endtask

    initial begin
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            fc[i] = 0; we[i] = 0; wa[i] = 0;
        end
        m_reset();
        #12;
        check_all();
        chk("rst_rd58", 32'(addr_rd[0]), 58);
        chk("rst_rdy", 32'(win_rdy[0]), 0);
        rst = 0;

        repeat (7) step(0, 1, 0, 0, 1, 0);
        chk("wr7_addr", 32'(addr_wr[0]), 56);
        chk("wr7_rdy", 32'(win_rdy[0]), 0);
        step(0, 1, 0, 0, 1, 0);
        chk("wr8_addr", 32'(addr_wr[0]), 64);
        chk("wr8_rdy", 32'(win_rdy[0]), 1);
        repeat (90) step(0, 1, 0, 0, 1, 0);
        chk("full_addr", 32'(addr_wr[0]), 784);

        repeat (25) step(0, 0, 1, 0, 0, 0);
        chk("s1_adv25_rd", 32'(addr_rd[0]), 83);
        chk("s1_adv25_col", 32'(win_col[0]), 25);
        step(0, 0, 1, 0, 0, 0);
        chk("s1_wrap_rd", 32'(addr_rd[0]), 86);
        chk("s1_wrap_row", 32'(win_row[0]), 1);
        chk("s1_wrap_col", 32'(win_col[0]), 0);

        repeat (12) step(0, 0, 0, 0, 0, 1);
        chk("s2_adv12_col", 32'(win_col[1]), 24);
        chk("s2_adv12_rd", 32'(addr_rd[1]), 82);
        step(0, 0, 0, 0, 0, 1);
        chk("s2_wrap_rd", 32'(addr_rd[1]), 114);
        chk("s2_wrap_row", 32'(win_row[1]), 2);
        chk("s2_wrap_col", 32'(win_col[1]), 0);

        run_done(0, 70, 3000);
        chk("end_rdy", 32'(win_rdy[0]), 0);
        chk("end_rd783", 32'(addr_rd[0]), 783);
        step(0, 1, 0, 0, 0, 0);
        chk("ovf_set", 32'(ovf[0]), 1);
        chk("ovf_addr", 32'(addr_wr[0]), 784);

        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 1);
        chk("idle_adv_rd", 32'(addr_rd[0]), 58);
        repeat (3) step(0, 1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 1, 0);
        chk("clr_drops_wr", 32'(addr_wr[0]), 0);
        repeat (8) step(0, 1, 0, 0, 1, 0);
        step(0, 1, 1, 0, 1, 1);
        chk("both_wr", 32'(addr_wr[0]), 72);
        chk("both_col", 32'(win_col[0]), 1);
        chk("both_rd", 32'(addr_rd[1]), 60);

        repeat (150) rand_step(50, 50);
        @(negedge clk);
        #2 rst = 1;
        #1;
        m_reset();
        check_all();
        chk("async_rst_rd", 32'(addr_rd[0]), 58);
        chk("async_rst_wr", 32'(addr_wr[1]), 0);
        #3 rst = 0;
        run_done(50, 60, 5000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
